serial_add_ctrl: RTL



---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/FullAdder.sv | 13 +
 rtl/serial_add_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  // 2'd3 is unused; the controller treats it as a fault and returns to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/ready/done handshake plus operand and result buses of the serial adder.
interface serial_add_ctrl_if
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/FullAdder.sv
// One-bit full adder cell shared by the serial arithmetic blocks.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder cell walks LSB-first over WIDTH cycles, then pulses done.
module serial_add_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ready_q, busy_q, done_q;
  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] sum_shift;

  FullAdder u_fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .C    (carry_q),
    .Sum  (cell_sum),
    .Carry(cell_carry)
  );

  // Written as shift-then-set so WIDTH=1 needs no empty slice.
  always_comb begin
    sum_shift            = sum_sr_q >> 1;
    sum_shift[WIDTH-1]   = cell_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_sr_q   <= bus.a;
            b_sr_q   <= bus.b;
            carry_q  <= bus.cin;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            state_q  <= StRun;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        StRun: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_shift;
          carry_q  <= cell_carry;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            sum_q   <= sum_shift;
            cout_q  <= cell_carry;
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule
